// File: rtl/mem_access_unit_pkg.sv
// Shared MEM-stage definitions: opcodes, access-unit FSM states, access sizes
// and the byte-lane helpers used by the load/store unit.
package mips_defs;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUSY = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef struct packed {
    logic  is_load;
    logic  is_store;
    size_e size;
    logic  sgn;
  } mem_op_t;

  function automatic mem_op_t decode_op(input logic [5:0] op);
    mem_op_t d;
    d = '0;
    case (op)
      OP_LB:   begin d.is_load = 1'b1; d.size = SZ_B; d.sgn = 1'b1; end
      OP_LH:   begin d.is_load = 1'b1; d.size = SZ_H; d.sgn = 1'b1; end
      OP_LW:   begin d.is_load = 1'b1; d.size = SZ_W; end
      OP_LBU:  begin d.is_load = 1'b1; d.size = SZ_B; end
      OP_LHU:  begin d.is_load = 1'b1; d.size = SZ_H; end
      OP_SB:   begin d.is_store = 1'b1; d.size = SZ_B; end
      OP_SH:   begin d.is_store = 1'b1; d.size = SZ_H; end
      OP_SW:   begin d.is_store = 1'b1; d.size = SZ_W; end
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return |off;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return 4'b0011 << {off[1], 1'b0};
      SZ_W:    return 4'b1111;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input size_e sz, input logic [31:0] wd);
    case (sz)
      SZ_B:    return {4{wd[7:0]}};
      SZ_H:    return {2{wd[15:0]}};
      SZ_W:    return wd;
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extract.sv
// Picks the addressed byte/halfword out of a little-endian read word and
// sign- or zero-extends it to 32 bits.
module load_extract
  import mips_defs::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  size_e       size_i,
  input  logic        sgn_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by extension
  always_comb begin
    byte_s = word_i[{off_i, 3'b000} +: 8];
    half_s = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      SZ_B:    data_o = {{24{sgn_i & byte_s[7]}}, byte_s};
      SZ_H:    data_o = {{16{sgn_i & half_s[15]}}, half_s};
      SZ_W:    data_o = word_i;
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one req/ack bus access per memory
// instruction, stalls the pipeline while it is outstanding, returns load data.
module mem_access_unit
  import mips_defs::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        InterruptRequest,
  input  logic [31:0] InstrM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [3:0]  BusBe,
  output logic [31:0] BusWData,
  input  logic        BusAck,
  input  logic [31:0] BusRData,
  output logic        StallM,
  output logic [31:0] LoadDataM,
  output logic        LoadValidM,
  output logic        AdELM,
  output logic        AdESM,
  output logic        BusErrM
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  ms_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d, lvalid_q, lvalid_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ldata_q, ldata_d;
  logic [3:0]  be_q, be_d;
  size_e       size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [1:0]  off_q, off_d;

  mem_op_t     op_s;
  logic        mis_s, issue_s;
  logic [31:0] ext_s;
  logic        unused_s;

  assign unused_s = ^InstrM[25:0];
  assign op_s     = decode_op(InstrM[31:26]);
  assign mis_s    = misaligned(op_s.size, ALUOutM[1:0]);
  assign issue_s  = (state_q == MS_IDLE) && (op_s.is_load || op_s.is_store)
                    && !mis_s && !InterruptRequest;

  // Pipeline-facing combinational outputs; all forced low while reset is held
  assign StallM = !reset && (issue_s || (state_q == MS_BUSY));
  assign AdELM  = !reset && (state_q == MS_IDLE) && op_s.is_load && mis_s;
  assign AdESM  = !reset && (state_q == MS_IDLE) && op_s.is_store && mis_s;

  load_extract u_load_extract (
    .word_i (BusRData),
    .off_i  (off_q),
    .size_i (size_q),
    .sgn_i  (sgn_q),
    .data_o (ext_s)
  );

  // Next-state and next-output logic; completion flags live for the DONE cycle only
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    ldata_d  = ldata_q;
    size_d   = size_q;
    sgn_d    = sgn_q;
    off_d    = off_q;
    lvalid_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      MS_IDLE: begin
        if (issue_s) begin
          req_d   = 1'b1;
          we_d    = op_s.is_store;
          addr_d  = {ALUOutM[31:2], 2'b00};
          be_d    = byte_en(op_s.size, ALUOutM[1:0]);
          wdata_d = lane_data(op_s.size, WriteDataM);
          size_d  = op_s.size;
          sgn_d   = op_s.sgn;
          off_d   = ALUOutM[1:0];
          cnt_d   = '0;
          state_d = MS_BUSY;
        end else begin
          state_d = MS_IDLE;
        end
      end
      MS_BUSY: begin
        if (BusAck) begin
          req_d = 1'b0;
          if (!we_q) begin
            ldata_d  = ext_s;
            lvalid_d = 1'b1;
          end else begin
            ldata_d = ldata_q;
          end
          state_d = MS_DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          ldata_d = 32'h0000_0000;
          state_d = MS_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MS_DONE: state_d = MS_IDLE;
      default: state_d = MS_IDLE;
    endcase
  end

  // State and registered bus/result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MS_IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0000_0000;
      be_q     <= 4'h0;
      wdata_q  <= 32'h0000_0000;
      ldata_q  <= 32'h0000_0000;
      lvalid_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= SZ_B;
      sgn_q    <= 1'b0;
      off_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      ldata_q  <= ldata_d;
      lvalid_q <= lvalid_d;
      err_q    <= err_d;
      size_q   <= size_d;
      sgn_q    <= sgn_d;
      off_q    <= off_d;
    end
  end

  assign BusReq     = req_q;
  assign BusWe      = we_q;
  assign BusAddr    = addr_q;
  assign BusBe      = be_q;
  assign BusWData   = wdata_q;
  assign LoadDataM  = ldata_q;
  assign LoadValidM = lvalid_q;
  assign BusErrM    = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: hand-derived vector table, corner
// sequences (timeout, late ack, interrupt, reset mid-access) and random ops.
module tb_mem_access_unit;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        irq = 1'b0;
  logic [31:0] instr = 32'h0, aluout = 32'h0, wdata = 32'h0, rdata = 32'h0;
  logic        ack = 1'b0;
  logic        BusReq, BusWe, StallM, LoadValidM, AdELM, AdESM, BusErrM;
  logic [31:0] BusAddr, BusWData, LoadDataM;
  logic [3:0]  BusBe;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.TIMEOUT(TMO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .InterruptRequest(irq),
    .InstrM(instr), .ALUOutM(aluout), .WriteDataM(wdata),
    .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr), .BusBe(BusBe),
    .BusWData(BusWData), .BusAck(ack), .BusRData(rdata),
    .StallM(StallM), .LoadDataM(LoadDataM), .LoadValidM(LoadValidM),
    .AdELM(AdELM), .AdESM(AdESM), .BusErrM(BusErrM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, addr, wd, rdata;
    int          ack_after;
    logic        issue, ld, adel, ades;
    logic [3:0]  be;
    logic [31:0] wdat, ldat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [5:0] op, input logic [31:0] addr, wd, rd,
                               input int ack_after, input logic issue, ld, adel, ades,
                               input logic [3:0] be, input logic [31:0] wdat, ldat);
    vec_t v;
    v.instr = {op, 26'h0}; v.addr = addr; v.wd = wd; v.rdata = rd;
    v.ack_after = ack_after; v.issue = issue; v.ld = ld; v.adel = adel; v.ades = ades;
    v.be = be; v.wdat = wdat; v.ldat = ldat;
    return v;
  endfunction

  // Reference: sizes in bytes, lanes by little-endian byte offset, plain arithmetic
  function automatic vec_t model(input logic [31:0] ins, addr, wd, rd, input int ack_after);
    vec_t v;
    int n, off;
    bit sgn, mem;
    longint mask, val;
    v.instr = ins; v.addr = addr; v.wd = wd; v.rdata = rd; v.ack_after = ack_after;
    mem = 1; sgn = 0; v.ld = 0; n = 4;
    case (int'(ins >> 26))
      'h20: begin n = 1; sgn = 1; v.ld = 1; end
      'h21: begin n = 2; sgn = 1; v.ld = 1; end
      'h23: begin n = 4; v.ld = 1; end
      'h24: begin n = 1; v.ld = 1; end
      'h25: begin n = 2; v.ld = 1; end
      'h28: n = 1;
      'h29: n = 2;
      'h2B: n = 4;
      default: mem = 0;
    endcase
    off = (int'(addr % 4) / n) * n;
    v.issue = mem && (addr % n == 0);
    v.adel = mem && v.ld && (addr % n != 0);
    v.ades = mem && !v.ld && (addr % n != 0);
    v.be = 4'(((1 << n) - 1) << off);
    for (int i = 0; i < 4; i++) v.wdat[8*i +: 8] = wd[8*(i % n) +: 8];
    mask = (64'sd1 << (8 * n)) - 1;
    val = (longint'(rd) >> (8 * off)) & mask;
    if (sgn && ((val >> (8 * n - 1)) & 1) == 1) val = val | (~mask & 64'hFFFF_FFFF);
    v.ldat = 32'(val);
    return v;
  endfunction

  // Caller is #1 after a rising edge with the unit in IDLE; returns the same way
  task automatic run(input vec_t v, input string nm);
    int k, exp_busy, stall_cnt;
    bit acked;
    instr = v.instr; aluout = v.addr; wdata = v.wd; rdata = v.rdata; ack = 1'b0;
    @(negedge clk);
    chk({nm, " stall@issue"}, StallM, v.issue);
    chk({nm, " AdEL"}, AdELM, v.adel);
    chk({nm, " AdES"}, AdESM, v.ades);
    chk({nm, " req@issue"}, BusReq, 1'b0);
    if (!v.issue) begin
      @(posedge clk); #1; instr = 32'h0;
      @(negedge clk);
      chk({nm, " no req"}, BusReq, 1'b0);
      @(posedge clk); #1;
      return;
    end
    stall_cnt = 1;
    acked = (v.ack_after >= 0) && (v.ack_after < TMO);
    exp_busy = acked ? v.ack_after + 1 : TMO;
    @(posedge clk); #1;
    for (k = 0; k < 40 && StallM; k++) begin
      ack = (k == v.ack_after);
      if (k == 0) begin
        @(negedge clk);
        chk({nm, " BusReq"}, BusReq, 1'b1);
        chk({nm, " BusWe"}, BusWe, !v.ld);
        chk({nm, " BusAddr"}, BusAddr, {v.addr[31:2], 2'b00});
        chk({nm, " BusBe"}, BusBe, v.be);
        if (!v.ld) chk({nm, " BusWData"}, BusWData, v.wdat);
      end
      stall_cnt++;
      @(posedge clk); #1; ack = 1'b0;
    end
    instr = 32'h0;
    chk({nm, " busy cycles"}, k, exp_busy);
    chk({nm, " stall cycles"}, stall_cnt, exp_busy + 1);
    @(negedge clk);
    chk({nm, " done stall"}, StallM, 1'b0);
    chk({nm, " done req"}, BusReq, 1'b0);
    chk({nm, " LoadValid"}, LoadValidM, v.ld && acked);
    chk({nm, " BusErr"}, BusErrM, !acked);
    if (v.ld || !acked) chk({nm, " LoadData"}, LoadDataM, acked ? v.ldat : 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, " flags clear"}, {LoadValidM, BusErrM}, 2'b00);
    @(posedge clk); #1;
  endtask

  vec_t tbl[$];
  vec_t v;
  logic [5:0] ops [11] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B,
                           6'h00, 6'h0F, 6'h2A};
  logic [31:0] rnd;

  initial begin
    // reset state, with a misaligned lw presented to show flags stay low
    instr = {6'h23, 26'h0}; aluout = 32'h1002;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst StallM", StallM, 1'b0);
    chk("rst AdELM", AdELM, 1'b0);
    chk("rst BusReq", BusReq, 1'b0);
    chk("rst outs", {BusWe, BusBe, LoadValidM, BusErrM}, 7'h0);
    chk("rst LoadData", LoadDataM, 32'h0);
    @(posedge clk); #1; reset = 1'b0; instr = 32'h0;

    tbl.push_back(mkv(6'h23, 32'h1004, 32'h12345678, 32'hDEADBEEF, 0, 1, 1, 0, 0, 4'hF, 32'h12345678, 32'hDEADBEEF));
    tbl.push_back(mkv(6'h20, 32'h1003, 32'h0, 32'h80112233, 0, 1, 1, 0, 0, 4'b1000, 32'h0, 32'hFFFFFF80));
    tbl.push_back(mkv(6'h24, 32'h1003, 32'h0, 32'h80112233, 0, 1, 1, 0, 0, 4'b1000, 32'h0, 32'h00000080));
    tbl.push_back(mkv(6'h29, 32'h2002, 32'h0000ABCD, 32'h0, 1, 1, 0, 0, 0, 4'b1100, 32'hABCDABCD, 32'h0));
    tbl.push_back(mkv(6'h28, 32'h2001, 32'h000000EE, 32'h0, 2, 1, 0, 0, 0, 4'b0010, 32'hEEEEEEEE, 32'h0));
    tbl.push_back(mkv(6'h23, 32'h1002, 32'h0, 32'h0, 0, 0, 1, 1, 0, 4'h0, 32'h0, 32'h0));
    tbl.push_back(mkv(6'h29, 32'h2001, 32'h0, 32'h0, 0, 0, 0, 0, 1, 4'h0, 32'h0, 32'h0));
    tbl.push_back(mkv(6'h21, 32'h1002, 32'h0, 32'h80112233, 3, 1, 1, 0, 0, 4'b1100, 32'h0, 32'hFFFF8011));
    tbl.push_back(mkv(6'h25, 32'h1000, 32'h0, 32'h80118233, 0, 1, 1, 0, 0, 4'b0011, 32'h0, 32'h00008233));
    tbl.push_back(mkv(6'h21, 32'h1000, 32'h0, 32'h80118233, 0, 1, 1, 0, 0, 4'b0011, 32'h0, 32'hFFFF8233));
    tbl.push_back(mkv(6'h20, 32'h1000, 32'h0, 32'h0000007F, 1, 1, 1, 0, 0, 4'b0001, 32'h0, 32'h0000007F));
    tbl.push_back(mkv(6'h2B, 32'h3008, 32'hCAFEF00D, 32'h0, TMO - 1, 1, 0, 0, 0, 4'hF, 32'hCAFEF00D, 32'h0));
    tbl.push_back(mkv(6'h00, 32'h1001, 32'h0, 32'h0, 0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0));
    tbl.push_back(mkv(6'h2A, 32'h1001, 32'h0, 32'h0, 0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0));
    for (int i = 0; i < tbl.size(); i++) run(tbl[i], $sformatf("vec%0d", i));

    // timeout, then an ack arriving while idle must be ignored
    run(mkv(6'h23, 32'h3000, 32'h0, 32'h11111111, -1, 1, 1, 0, 0, 4'hF, 32'h0, 32'h0), "timeout");
    ack = 1'b1; rdata = 32'h22222222;
    @(posedge clk); #1; ack = 1'b0;
    @(negedge clk);
    chk("late ack valid", LoadValidM, 1'b0);
    chk("late ack err", BusErrM, 1'b0);
    chk("late ack req", BusReq, 1'b0);
    chk("late ack data", LoadDataM, 32'h0);
    @(posedge clk); #1;

    // interrupt blocks issue of a pending sw
    irq = 1'b1; instr = {6'h2B, 26'h0}; aluout = 32'h5000; wdata = 32'h1;
    @(negedge clk);
    chk("irq stall", StallM, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("irq no req", BusReq, 1'b0);
    @(posedge clk); #1; irq = 1'b0; instr = 32'h0;

    for (int i = 0; i < 40; i++) begin
      rnd = $urandom;
      v = model({ops[$urandom_range(0, 10)], rnd[25:0]}, $urandom, $urandom, $urandom,
                int'($urandom_range(0, 19)));
      run(v, $sformatf("rnd%0d", i));
    end

    // reset on the third BUSY cycle of a store, after a load left data behind
    run(tbl[0], "pre-reset lw");
    instr = {6'h2B, 26'h0}; aluout = 32'h4000; wdata = 32'h55AA55AA;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(negedge clk);
    chk("midrst StallM", StallM, 1'b0);
    @(posedge clk); #1;
    chk("midrst BusReq", BusReq, 1'b0);
    chk("midrst BusWe", BusWe, 1'b0);
    chk("midrst BusAddr", BusAddr, 32'h0);
    chk("midrst BusBe", BusBe, 4'h0);
    chk("midrst BusWData", BusWData, 32'h0);
    chk("midrst LoadData", LoadDataM, 32'h0);
    chk("midrst flags", {LoadValidM, BusErrM}, 2'b00);
    reset = 1'b0; instr = 32'h0; ack = 1'b1;
    @(negedge clk);
    chk("postrst idle stall", StallM, 1'b0);
    @(posedge clk); #1; ack = 1'b0;
    @(negedge clk);
    chk("postrst no valid", LoadValidM, 1'b0);
    chk("postrst no req", BusReq, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
